// File: rtl/button_event_counter_pkg.sv
// Shared definitions for debounced push-button / switch inputs on the 100 MHz board clock.
package button_event_counter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms debounce, 0.5 s initial repeat delay, 0.1 s repeat period at 100 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_REPEAT_DELAY    = 50000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_counter_sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous board inputs (buttons, switches).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/button_event_counter.sv
// Debounced push-button with one-cycle press strobe and wrapping event counter.
// Define BUTTON_EVENT_COUNTER_AUTO_REPEAT_EN to emit repeat strobes while the button is held.
module button_event_counter
  import button_event_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int COUNT_W         = 16,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_in,
  input  logic               enable,
  output logic               btn_level,
  output logic               press_pulse,
  output logic [COUNT_W-1:0] count
);

  localparam int TIMER_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [TIMER_W-1:0] DB_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

  logic               s;
  btn_state_t         state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               press_pulse_reg, press_pulse_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               repeat_fire;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );

`ifdef BUTTON_EVENT_COUNTER_AUTO_REPEAT_EN
  localparam logic [TIMER_W-1:0] REP_DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] REP_PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

  logic [TIMER_W-1:0] rep_timer_reg;
  logic               repeating_reg;

  // Only fire while staying in HELD; the first repeat waits the longer delay.
  always_comb begin
    repeat_fire = 1'b0;
    if (state_reg == HELD && state_next == HELD) begin
      if (repeating_reg)
        repeat_fire = (rep_timer_reg == REP_PERIOD_LAST);
      else
        repeat_fire = (rep_timer_reg == REP_DELAY_LAST);
    end
  end

  // Held outside HELD at zero, so every entry into HELD restarts the delay.
  always_ff @(posedge clk) begin
    if (reset || state_reg != HELD) begin
      rep_timer_reg <= '0;
      repeating_reg <= 1'b0;
    end else if (repeat_fire) begin
      rep_timer_reg <= '0;
      repeating_reg <= 1'b1;
    end else begin
      rep_timer_reg <= rep_timer_reg + 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        if (s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s)                    state_next = IDLE;
        else if (timer_reg == DB_LAST) state_next = HELD;
        else                       timer_next = timer_reg + 1'b1;
      end
      HELD: begin
        if (!s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (s)                     state_next = HELD;
        else if (timer_reg == DB_LAST) state_next = IDLE;
        else                       timer_next = timer_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state_reg) timer_next = '0;

    // Bouncing back from RELEASE_WAIT into HELD is not a new press.
    press_pulse_next = (state_reg == PRESS_WAIT && state_next == HELD) || repeat_fire;
    count_next       = count_reg + COUNT_W'(press_pulse_reg && enable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      press_pulse_reg <= 1'b0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      press_pulse_reg <= press_pulse_next;
      count_reg       <= count_next;
    end
  end

  assign btn_level   = (state_reg == HELD) || (state_reg == RELEASE_WAIT);
  assign press_pulse = press_pulse_reg;
  assign count       = count_reg;

endmodule

// File: tb/tb_button_event_counter.sv
// Directed bench for button_event_counter (DEBOUNCE_CYCLES=4, COUNT_W=4, REPEAT_DELAY=8, REPEAT_PERIOD=3).
module tb_button_event_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       enable;
  logic       btn_level;
  logic       press_pulse;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  button_event_counter #(
    .DEBOUNCE_CYCLES (4),
    .COUNT_W         (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .enable      (enable),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are looked at 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One clean press (held 9 cycles) then a full release; returns pulses seen.
  task automatic clean_press(output int pulses);
    pulses = 0;
    btn_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (press_pulse) pulses++;
    end
    btn_in = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (press_pulse) pulses++;
    end
  endtask

  task automatic test_reset();
    btn_in = 1'b0;
    enable = 1'b1;
    do_reset();
    total++;
    if (btn_level !== 1'b0 || press_pulse !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: level=%b pulse=%b count=%0d, required 0/0/0", btn_level, press_pulse, count);
    end
    $display("reset: level=%b pulse=%b count=%0d", btn_level, press_pulse, count);
  endtask

  task automatic test_press();
    int pulses, first;
    logic [3:0] cnt_at8;
    pulses = 0; first = -1; cnt_at8 = 4'hx;
    btn_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (press_pulse) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == 8) cnt_at8 = count;
    end
    total++;
    if (pulses !== 1 || first !== 7) begin
      bad++;
      $display("FAIL press_latency: pulses=%0d at cycle %0d, required 1 at cycle 7", pulses, first);
    end
    total++;
    if (cnt_at8 !== 4'd1) begin
      bad++;
      $display("FAIL press_count: count=%0d one cycle after pulse, required 1", cnt_at8);
    end
    total++;
    if (btn_level !== 1'b1) begin
      bad++;
      $display("FAIL press_level: level=%b while held, required 1", btn_level);
    end
    btn_in = 1'b0;
    for (int k = 0; k < 20; k++) step();
    total++;
    if (btn_level !== 1'b0 || count !== 4'd1) begin
      bad++;
      $display("FAIL release: level=%b count=%0d, required 0/1", btn_level, count);
    end
    $display("press: pulses=%0d first=%0d count=%0d level=%b", pulses, first, count, btn_level);
  endtask

  task automatic test_glitch();
    int pulses;
    logic level_seen;
    pulses = 0; level_seen = 1'b0;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      btn_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        if (press_pulse) pulses++;
        level_seen |= btn_level;
      end
      btn_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step();
        if (press_pulse) pulses++;
        level_seen |= btn_level;
      end
    end
    total++;
    if (pulses !== 0 || level_seen !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL glitch: pulses=%0d level_seen=%b count=%0d, required 0/0/0", pulses, level_seen, count);
    end
    $display("glitch: pulses=%0d level_seen=%b count=%0d", pulses, level_seen, count);
  endtask

  task automatic test_bounce();
    int pulses;
    logic level_dropped;
    pulses = 0; level_dropped = 1'b0;
    do_reset();
    btn_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (press_pulse) pulses++;
    end
    for (int r = 0; r < 3; r++) begin
      btn_in = 1'b0;
      for (int k = 0; k < 2; k++) begin
        step();
        if (press_pulse) pulses++;
        if (!btn_level) level_dropped = 1'b1;
      end
      btn_in = 1'b1;
      for (int k = 0; k < 2; k++) begin
        step();
        if (press_pulse) pulses++;
        if (!btn_level) level_dropped = 1'b1;
      end
    end
    btn_in = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (press_pulse) pulses++;
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL bounce_pulses: pulses=%0d, required 1", pulses);
    end
    total++;
    if (level_dropped !== 1'b0) begin
      bad++;
      $display("FAIL bounce_level: level dropped=%b during bounces, required 0", level_dropped);
    end
    total++;
    if (btn_level !== 1'b0 || count !== 4'd1) begin
      bad++;
      $display("FAIL bounce_release: level=%b count=%0d, required 0/1", btn_level, count);
    end
    $display("bounce: pulses=%0d dropped=%b count=%0d", pulses, level_dropped, count);
  endtask

  task automatic test_wrap();
    int pulses;
    do_reset();
    enable = 1'b1;
    for (int p = 1; p <= 17; p++) begin
      clean_press(pulses);
      total++;
      if (pulses !== 1 || count !== 4'(p % 16)) begin
        bad++;
        $display("FAIL wrap_press%0d: pulses=%0d count=%0d, required 1/%0d", p, pulses, count, p % 16);
      end
      $display("wrap press %0d: pulses=%0d count=%0d", p, pulses, count);
    end
    enable = 1'b0;
    clean_press(pulses);
    total++;
    if (pulses !== 1 || count !== 4'd1) begin
      bad++;
      $display("FAIL enable_low: pulses=%0d count=%0d, required 1/1", pulses, count);
    end
    $display("enable low: pulses=%0d count=%0d", pulses, count);
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int pulses, first;
    logic [3:0] cnt_at8;
    pulses = 0; first = -1; cnt_at8 = 4'hx;
    do_reset();
    btn_in = 1'b1;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (press_pulse !== 1'b0 || btn_level !== 1'b0 || count !== 4'd0) begin
        bad++;
        $display("FAIL reset_mid_hold: pulse=%b level=%b count=%0d, required 0/0/0", press_pulse, btn_level, count);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (press_pulse) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == 8) cnt_at8 = count;
    end
    total++;
    if (pulses !== 1 || first !== 7 || cnt_at8 !== 4'd1) begin
      bad++;
      $display("FAIL reset_mid_after: pulses=%0d first=%0d count=%0d, required 1/7/1", pulses, first, cnt_at8);
    end
    $display("reset mid: pulses=%0d first=%0d count=%0d", pulses, first, cnt_at8);
    btn_in = 1'b0;
    for (int k = 0; k < 12; k++) step();
  endtask

  task automatic test_auto_repeat();
    int got[$];
    int exp[$];
`ifdef BUTTON_EVENT_COUNTER_AUTO_REPEAT_EN
    exp = '{7, 15, 18, 21, 24, 27, 30};
`else
    exp = '{7};
`endif
    do_reset();
    btn_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (press_pulse) got.push_back(k);
    end
    btn_in = 1'b0;
    for (int k = 0; k < 12; k++) step();
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("FAIL repeat_count: pulses=%0d, required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("FAIL repeat_pulse%0d: cycle=%0d, required %0d", i, got[i], exp[i]);
        end
      end
    end
    total++;
    if (count !== 4'(exp.size())) begin
      bad++;
      $display("FAIL repeat_total: count=%0d, required %0d", count, exp.size());
    end
    $display("hold 30: pulses=%0d count=%0d", got.size(), count);
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    enable = 1'b1;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_wrap();
    test_reset_mid();
    test_auto_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
